// File: rtl/bbox_scanner.sv
// bbox_scanner: walks every integer pixel of a screen-clipped bounding box
// in raster order (x fastest) and hands one pixel per handshake downstream.
// Coordinates are unsigned fixed point with FRAC_BITS fractional bits.
module bbox_scanner #(
    parameter int FRAC_BITS = 6,
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] XMIN,
    input  logic [15:0] XMAX,
    input  logic [15:0] YMIN,
    input  logic [15:0] YMAX,
    input  logic        BOX_VALID,
    output logic        BOX_READY,
    output logic [15:0] PX,
    output logic [15:0] PY,
    output logic        PIX_VALID,
    input  logic        PIX_READY,
    output logic        PIX_LAST,
    output logic [15:0] PIX_COUNT,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [15:0] STEP      = 16'(1 << FRAC_BITS);
    localparam logic [15:0] FRAC_MASK = ~(STEP - 16'd1);
    localparam logic [15:0] XLIM      = 16'((SCREEN_W - 1) << FRAC_BITS);
    localparam logic [15:0] YLIM      = 16'((SCREEN_H - 1) << FRAC_BITS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        FIN
    } state_e;

    state_e      state_q;
    logic [15:0] xMin_q;
    logic [15:0] xMax_q;
    logic [15:0] yMin_q;
    logic [15:0] yMax_q;
    logic [15:0] px_q;
    logic [15:0] py_q;
    logic [15:0] pixCount_q;
    logic [15:0] xMaxClip;
    logic [15:0] yMaxClip;

    // Clip the registered box maxima against the last visible pixel.
    always_comb begin
        xMaxClip = (xMax_q > XLIM) ? XLIM : xMax_q;
        yMaxClip = (yMax_q > YLIM) ? YLIM : yMax_q;
    end

    // Box FSM: accept, clip and empty-test, raster walk, end-of-box pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            xMin_q     <= 16'd0;
            xMax_q     <= 16'd0;
            yMin_q     <= 16'd0;
            yMax_q     <= 16'd0;
            px_q       <= 16'd0;
            py_q       <= 16'd0;
            pixCount_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (BOX_VALID) begin
                        xMin_q     <= XMIN & FRAC_MASK;
                        xMax_q     <= XMAX & FRAC_MASK;
                        yMin_q     <= YMIN & FRAC_MASK;
                        yMax_q     <= YMAX & FRAC_MASK;
                        pixCount_q <= 16'd0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    xMax_q <= xMaxClip;
                    yMax_q <= yMaxClip;
                    if ((xMin_q > xMaxClip) || (yMin_q > yMaxClip)) begin
                        state_q <= FIN;
                    end else begin
                        px_q    <= xMin_q;
                        py_q    <= yMin_q;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (PIX_READY) begin
                        if (pixCount_q != 16'hFFFF) begin
                            pixCount_q <= pixCount_q + 16'd1;
                        end
                        if (px_q < xMax_q) begin
                            px_q <= px_q + STEP;
                        end else if (py_q < yMax_q) begin
                            px_q <= xMin_q;
                            py_q <= py_q + STEP;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BOX_READY = (state_q == IDLE);
    assign PIX_VALID = (state_q == SCAN);
    assign DONE      = (state_q == FIN);
    assign BUSY      = (state_q != IDLE);
    assign PX        = px_q;
    assign PY        = py_q;
    assign PIX_COUNT = pixCount_q;
    assign PIX_LAST  = (state_q == SCAN) && (px_q == xMax_q) && (py_q == yMax_q);

endmodule

// File: tb/tb_bbox_scanner.sv
// tb_bbox_scanner: scoreboard bench for bbox_scanner on a 4x4-pixel screen,
// so clipping is reachable with small boxes. Expected pixels are queued when
// a box is driven and compared whenever the scanner presents a pixel.
module tb_bbox_scanner;

    localparam int FB   = 6;
    localparam int SW   = 4;
    localparam int SH   = 4;
    localparam int XLIM = (SW - 1) << FB;
    localparam int YLIM = (SH - 1) << FB;

    logic        CLK;
    logic        RST_N;
    logic [15:0] XMIN, XMAX, YMIN, YMAX;
    logic        BOX_VALID;
    logic        BOX_READY;
    logic [15:0] PX, PY;
    logic        PIX_VALID;
    logic        PIX_READY;
    logic        PIX_LAST;
    logic [15:0] PIX_COUNT;
    logic        BUSY;
    logic        DONE;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } pix_t;

    pix_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   doneSeen    = 0;
    int   readyMode   = 0;
    int   readyCyc    = 0;
    int   expLastX    = 0;
    int   expLastY    = 0;

    bbox_scanner #(
        .FRAC_BITS(FB),
        .SCREEN_W (SW),
        .SCREEN_H (SH)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .XMIN     (XMIN),
        .XMAX     (XMAX),
        .YMIN     (YMIN),
        .YMAX     (YMAX),
        .BOX_VALID(BOX_VALID),
        .BOX_READY(BOX_READY),
        .PX       (PX),
        .PY       (PY),
        .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY),
        .PIX_LAST (PIX_LAST),
        .PIX_COUNT(PIX_COUNT),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    // Free-running clock, rising edge active.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference model: truncate, clip, then enumerate the box in raster order.
    task automatic pushBox(input int xmin, input int xmax, input int ymin, input int ymax, output int count);
        int x0, x1, y0, y1;
        pix_t p;
        x0 = xmin & ~((1 << FB) - 1);
        x1 = xmax & ~((1 << FB) - 1);
        y0 = ymin & ~((1 << FB) - 1);
        y1 = ymax & ~((1 << FB) - 1);
        if (x1 > XLIM) x1 = XLIM;
        if (y1 > YLIM) y1 = YLIM;
        count = 0;
        if (x0 <= x1 && y0 <= y1) begin
            for (int y = y0; y <= y1; y += (1 << FB)) begin
                for (int x = x0; x <= x1; x += (1 << FB)) begin
                    p.x    = 16'(x);
                    p.y    = 16'(y);
                    p.last = (x == x1) && (y == y1);
                    expQ.push_back(p);
                    count++;
                end
            end
            expLastX = x1;
            expLastY = y1;
        end
    endtask

    // Drive PIX_READY for the coming cycle: always high, or a 1,0,0 pattern.
    task automatic driveReady();
        PIX_READY = (readyMode == 0) ? 1'b1 : ((readyCyc % 3) == 0);
        readyCyc++;
    endtask

    // Scoreboard consumer: every presented pixel must match the queue head,
    // which also proves PX/PY/PIX_LAST hold steady while stalled.
    always @(negedge CLK) begin
        if (RST_N && DONE) doneSeen++;
        if (RST_N && PIX_VALID) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected pixel", 32'd1, 32'd0);
            end else begin
                checkOutput("pixel x", 32'(PX), 32'(expQ[0].x));
                checkOutput("pixel y", 32'(PY), 32'(expQ[0].y));
                checkOutput("pixel last", 32'(PIX_LAST), 32'(expQ[0].last));
                if (PIX_READY) void'(expQ.pop_front());
            end
        end
    end

    // Step cycles until DONE is seen or the budget runs out.
    task automatic waitDone(input string tag);
        int i;
        i = 0;
        while (!DONE && i < 400) begin
            @(posedge CLK); #1;
            driveReady();
            i++;
        end
        checkOutput(tag, 32'(DONE), 32'd1);
    endtask

    // One complete box transaction with timing and end-of-box checks.
    task automatic applyStimulus(input logic [15:0] xmin, input logic [15:0] xmax,
                                 input logic [15:0] ymin, input logic [15:0] ymax, input int mode);
        int n;
        int w;
        bit empty;
        readyMode = mode;
        readyCyc  = 0;
        w = 0;
        while (!BOX_READY && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        checkOutput("box ready before accept", 32'(BOX_READY), 32'd1);
        pushBox(int'(xmin), int'(xmax), int'(ymin), int'(ymax), n);
        empty = (n == 0);
        XMIN = xmin; XMAX = xmax; YMIN = ymin; YMAX = ymax;
        BOX_VALID = 1'b1;
        driveReady();
        @(posedge CLK); #1;
        BOX_VALID = 1'b0;
        checkOutput("load busy", 32'(BUSY), 32'd1);
        checkOutput("load box_ready", 32'(BOX_READY), 32'd0);
        checkOutput("load count cleared", 32'(PIX_COUNT), 32'd0);
        checkOutput("load pix_valid", 32'(PIX_VALID), 32'd0);
        driveReady();
        @(posedge CLK); #1;
        checkOutput("first cycle pix_valid", 32'(PIX_VALID), 32'(!empty));
        checkOutput("first cycle done", 32'(DONE), 32'(empty));
        driveReady();
        waitDone("done pulse");
        checkOutput("fin count", 32'(PIX_COUNT), 32'(n));
        checkOutput("fin pix_valid", 32'(PIX_VALID), 32'd0);
        checkOutput("fin busy", 32'(BUSY), 32'd1);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        @(posedge CLK); #1;
        checkOutput("idle done low", 32'(DONE), 32'd0);
        checkOutput("idle box_ready", 32'(BOX_READY), 32'd1);
        checkOutput("idle busy", 32'(BUSY), 32'd0);
        checkOutput("idle count hold", 32'(PIX_COUNT), 32'(n));
        if (!empty) begin
            checkOutput("idle px hold", 32'(PX), 32'(expLastX));
            checkOutput("idle py hold", 32'(PY), 32'(expLastY));
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int n;
        int doneBefore;
        RST_N = 1'b0;
        XMIN = '0; XMAX = '0; YMIN = '0; YMAX = '0;
        BOX_VALID = 1'b0;
        PIX_READY = 1'b0;
        #1;
        checkOutput("reset box_ready", 32'(BOX_READY), 32'd1);
        checkOutput("reset pix_valid", 32'(PIX_VALID), 32'd0);
        checkOutput("reset busy", 32'(BUSY), 32'd0);
        checkOutput("reset done", 32'(DONE), 32'd0);
        checkOutput("reset px", 32'(PX), 32'd0);
        checkOutput("reset count", 32'(PIX_COUNT), 32'd0);
        checkOutput("reset last", 32'(PIX_LAST), 32'd0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        $display("[TB] basic scan");
        applyStimulus(16'd64, 16'd192, 16'd128, 16'd192, 0);
        $display("[TB] backpressure");
        applyStimulus(16'd64, 16'd192, 16'd128, 16'd192, 1);
        $display("[TB] empty box");
        applyStimulus(16'd256, 16'd128, 16'd0, 16'd0, 0);
        $display("[TB] truncation single pixel");
        applyStimulus(16'd100, 16'd100, 16'd100, 16'd100, 0);
        $display("[TB] x clipping");
        applyStimulus(16'd128, 16'd640, 16'd0, 16'd64, 0);
        $display("[TB] y clipping with stalls");
        applyStimulus(16'd0, 16'd0, 16'd128, 16'd1000, 1);
        $display("[TB] fully off-screen box");
        applyStimulus(16'd320, 16'd400, 16'd0, 16'd64, 0);

        $display("[TB] BOX_VALID held across a scan");
        readyMode = 0;
        readyCyc  = 0;
        pushBox(64, 192, 128, 192, n);
        pushBox(64, 192, 128, 192, n);
        XMIN = 16'd64; XMAX = 16'd192; YMIN = 16'd128; YMAX = 16'd192;
        BOX_VALID = 1'b1;
        driveReady();
        @(posedge CLK); #1;
        checkOutput("held load box_ready", 32'(BOX_READY), 32'd0);
        checkOutput("held load busy", 32'(BUSY), 32'd1);
        waitDone("held first done");
        checkOutput("held fin box_ready", 32'(BOX_READY), 32'd0);
        @(posedge CLK); #1;
        checkOutput("held idle box_ready", 32'(BOX_READY), 32'd1);
        checkOutput("held idle busy", 32'(BUSY), 32'd0);
        @(posedge CLK); #1;
        BOX_VALID = 1'b0;
        checkOutput("held second accept busy", 32'(BUSY), 32'd1);
        checkOutput("held second count cleared", 32'(PIX_COUNT), 32'd0);
        waitDone("held second done");
        checkOutput("held second count", 32'(PIX_COUNT), 32'(n));
        checkOutput("held scoreboard drained", 32'(expQ.size()), 32'd0);
        @(posedge CLK); #1;

        $display("[TB] reset mid-scan");
        readyMode = 0;
        readyCyc  = 0;
        pushBox(64, 192, 128, 192, n);
        XMIN = 16'd64; XMAX = 16'd192; YMIN = 16'd128; YMAX = 16'd192;
        BOX_VALID = 1'b1;
        driveReady();
        @(posedge CLK); #1;
        BOX_VALID = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        checkOutput("pre-reset third px", 32'(PX), 32'd192);
        checkOutput("pre-reset third py", 32'(PY), 32'd128);
        checkOutput("pre-reset count", 32'(PIX_COUNT), 32'd2);
        doneBefore = doneSeen;
        RST_N = 1'b0;
        #1;
        checkOutput("async reset pix_valid", 32'(PIX_VALID), 32'd0);
        checkOutput("async reset box_ready", 32'(BOX_READY), 32'd1);
        checkOutput("async reset busy", 32'(BUSY), 32'd0);
        checkOutput("async reset px", 32'(PX), 32'd0);
        checkOutput("async reset count", 32'(PIX_COUNT), 32'd0);
        expQ.delete();
        repeat (3) begin
            @(posedge CLK); #1;
            checkOutput("no done in reset", 32'(DONE), 32'd0);
        end
        RST_N = 1'b1;
        @(posedge CLK); #1;
        checkOutput("no done after abandon", 32'(doneSeen), 32'(doneBefore));
        applyStimulus(16'd64, 16'd192, 16'd128, 16'd192, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bbox_scanner.md
Name: bbox_scanner

Overview:
- Consumes one triangle bounding box (XMIN/XMAX/YMIN/YMAX, unsigned Q10.6, integer-aligned) produced by the bounding-box stage.
- Walks every integer pixel inside the box in raster order (x fastest, then y) and emits one pixel coordinate per handshake to the downstream edge-test/shading stage.
- Clips the box to the screen and reports empty boxes without emitting pixels.

Parameters:
FRAC_BITS, 6, fractional bits of the fixed-point coordinate format; one pixel step = 1<<FRAC_BITS
SCREEN_W, 320, screen width in pixels; x clip limit = (SCREEN_W-1)<<FRAC_BITS
SCREEN_H, 240, screen height in pixels; y clip limit = (SCREEN_H-1)<<FRAC_BITS

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
XMIN  input  16  box x minimum, Q10.6
XMAX  input  16  box x maximum, Q10.6
YMIN  input  16  box y minimum, Q10.6
YMAX  input  16  box y maximum, Q10.6
BOX_VALID  input  1  box inputs valid
BOX_READY  output  1  scanner can accept a box
PX  output  16  current pixel x, Q10.6, fractional bits zero
PY  output  16  current pixel y, Q10.6, fractional bits zero
PIX_VALID  output  1  PX/PY valid
PIX_READY  input  1  downstream accepts pixel
PIX_LAST  output  1  current pixel is the last of the box
PIX_COUNT  output  16  pixels handed off for current box
BUSY  output  1  box in progress (not IDLE)
DONE  output  1  one-cycle pulse at end of box (including empty boxes)

Behaviour:
- Clock and reset: single clock CLK; reset is asynchronous and active-low on RST_N. On reset all outputs go to 0 except BOX_READY=1, and the FSM goes to IDLE. Reset asserted mid-scan abandons the box immediately: no DONE pulse, PIX_VALID drops asynchronously.
- FSM states: IDLE, LOAD, SCAN, FIN.
- IDLE:
  - BOX_READY=1.
  - On BOX_VALID&BOX_READY at edge N, register the four inputs with the low FRAC_BITS forced to 0 (truncate), clear PIX_COUNT, and go to LOAD.
  - BOX_READY=0 in every other state.
- LOAD (one cycle):
  - xmax_c = min(XMAX, XLIM); ymax_c = min(YMAX, YLIM). All comparisons are unsigned.
  - If XMIN>xmax_c or YMIN>ymax_c, the box is empty: go to FIN.
  - Otherwise set PX=XMIN, PY=YMIN and go to SCAN.
  - First PIX_VALID is high in cycle N+2.
- SCAN:
  - PIX_VALID=1. PX, PY and PIX_LAST stay stable while PIX_READY=0.
  - On PIX_VALID&PIX_READY, PIX_COUNT increments, then:
    - If PX<xmax_c: PX += step.
    - Else if PY<ymax_c: PX=XMIN, PY += step.
    - Else go to FIN.
  - Throughput is one pixel per cycle when PIX_READY is held high; there is no bubble at row wrap.
  - PIX_LAST = (PX==xmax_c)&&(PY==ymax_c), combinational from registered state.
- FIN (one cycle):
  - DONE=1 and PIX_VALID=0, then go to IDLE.
  - The earliest next box accept is the cycle after FIN.
  - PX, PY and PIX_COUNT hold their final values until the next accept.
- Arithmetic:
  - 16-bit unsigned throughout; the step adder never overflows because the clip limits stay below 2^16.
  - The comparison against xmax_c happens before incrementing, so there is no wrap-around.
  - PIX_COUNT saturates at 0xFFFF.
- BUSY=1 in LOAD, SCAN and FIN.
- BOX_VALID while busy is ignored; no box is queued.
- PIX_READY high while PIX_VALID=0 has no effect.

Test Plan:
- Basic scan: box XMIN=64, XMAX=192, YMIN=128, YMAX=192, PIX_READY=1 -> six pixels (64,128),(128,128),(192,128),(64,192),(128,192),(192,192) on consecutive cycles starting at N+2. PIX_LAST is high only on the 6th pixel, DONE pulses the next cycle, PIX_COUNT=6.
- Backpressure: same box, PIX_READY toggling 1,0,0,1,... -> PX/PY/PIX_LAST stay stable while stalled, the same 6-pixel order results, no duplicates or drops, PIX_COUNT=6.
- Empty and truncation: XMIN=256, XMAX=128 -> no PIX_VALID, DONE at N+2. Separately, XMIN=XMAX=YMIN=YMAX=100 truncates to 64 and gives a single pixel (64,64) with PIX_LAST=1.
- Clipping: with SCREEN_W=4, SCREEN_H=4 and box x 128..640, y 0..64 -> x is clipped to 192, giving 4 pixels (128,0),(192,0),(128,64),(192,64). Box XMIN=320 gives an empty box with DONE.
- Busy and handshake: BOX_VALID held high across a scan -> BOX_READY=0 and the second box is not accepted until the cycle after DONE. BUSY is high from N+1 through the FIN cycle.
- Reset mid-scan: RST_N low during the 3rd pixel of the basic box -> all outputs reset immediately, no DONE. After release, a new box scans correctly from its first pixel with PIX_COUNT starting at 0.
